// File: rtl/vm_pkg.sv
// Types and constants shared by the vending-machine controller and the change dispenser.
package vm_pkg;

  typedef enum logic [2:0] {IDLE, FEED, GAP, FIN, JAM} disp_state_t;

  localparam int COIN_MAX_DEF = 4;

  typedef logic [2:0] change_t;

  function automatic change_t clamp_change(change_t c, int lim);
    return (int'(c) > lim) ? change_t'(lim) : c;
  endfunction

endpackage

// File: rtl/disp_timer.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module disp_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-hopper payout sequencer. Define CHANGE_DISP_TIMEOUT_EN to enable the
// FEED timeout and the JAM state; without it FEED waits for coin_sense forever.
//
// state | meaning
// IDLE  | waiting for req
// FEED  | solenoid driven, waiting for coin_sense
// GAP   | solenoid released for GAP_W cycles between coins
// FIN   | one-cycle done pulse
// JAM   | hopper timed out, waiting for clr
module change_dispenser
  import vm_pkg::*;
#(
  parameter int GAP_W    = 2,
  parameter int TIMEOUT  = 16,
  parameter int COIN_MAX = COIN_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [2:0] change,
  input  logic       coin_sense,
  input  logic       clr,
  output logic       coin_out,
  output logic       busy,
  output logic       done,
  output logic       jam,
  output logic [2:0] remaining
);

  localparam int GW = $clog2(GAP_W + 1);

  disp_state_t state_q, state_d;
  change_t     rem_q, rem_d;
  logic        gap_load, gap_dec, gap_zero;
  logic        to_expired;

  assign gap_load = (state_q == FEED) && coin_sense;
  assign gap_dec  = (state_q == GAP);

  disp_timer #(.W(GW)) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .dec      (gap_dec),
    .load_val (GW'(GAP_W - 1)),
    .zero     (gap_zero)
  );

`ifdef CHANGE_DISP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic to_load, to_dec, to_zero;

  // Reloaded on every entry to FEED so each coin gets a fresh TIMEOUT window.
  assign to_load = ((state_q == IDLE) && req && (change != '0)) ||
                   ((state_q == GAP) && gap_zero && (rem_q != '0));
  assign to_dec  = (state_q == FEED) && !coin_sense;

  disp_timer #(.W(TW)) u_to_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (to_load),
    .dec      (to_dec),
    .load_val (TW'(TIMEOUT - 1)),
    .zero     (to_zero)
  );

  assign to_expired = to_zero;
`else
  assign to_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = (change == '0) ? FIN : FEED;
      FEED: begin
        if (coin_sense)      state_d = GAP;
        else if (to_expired) state_d = JAM;
      end
      GAP:  if (gap_zero) state_d = (rem_q == '0) ? FIN : FEED;
      FIN:  state_d = IDLE;
      JAM:  if (clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rem_d = rem_q;
    if ((state_q == IDLE) && req && (change != '0))
      rem_d = clamp_change(change, COIN_MAX);
    else if ((state_q == FEED) && coin_sense && (rem_q != '0))
      rem_d = rem_q - 3'd1;
    else if ((state_q == JAM) && clr)
      rem_d = '0;
  end

  always_comb begin
    coin_out  = (state_q == FEED);
    busy      = (state_q == FEED) || (state_q == GAP) || (state_q == JAM);
    done      = (state_q == FIN);
`ifdef CHANGE_DISP_TIMEOUT_EN
    jam       = (state_q == JAM);
`else
    jam       = 1'b0;
`endif
    remaining = rem_q;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser; a behavioural hopper answers coin_out.
module tb_change_dispenser;

  localparam int GAP_W    = 2;
  localparam int TIMEOUT  = 16;
  localparam int COIN_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [2:0] change = '0;
  logic       coin_sense = 1'b0;
  logic       clr = 1'b0;
  logic       coin_out, busy, done, jam;
  logic [2:0] remaining;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];

  bit hop_en = 1'b0;
  int hop_dly = 0;
  int hi_cnt = 0;

  change_dispenser #(.GAP_W(GAP_W), .TIMEOUT(TIMEOUT), .COIN_MAX(COIN_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .change     (change),
    .coin_sense (coin_sense),
    .clr        (clr),
    .coin_out   (coin_out),
    .busy       (busy),
    .done       (done),
    .jam        (jam),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  // Hopper: drops a coin after coin_out has been high for hop_dly+1 cycles.
  always @(negedge clk) begin
    if (hop_en && coin_out) begin
      hi_cnt++;
      coin_sense = (hi_cnt > hop_dly);
    end else begin
      hi_cnt = 0;
      coin_sense = 1'b0;
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (coin_out !== 1'b0) begin n_fail++; $display("FAIL reset_coin_out got %b want 0", coin_out); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_chk++; if (jam !== 1'b0) begin n_fail++; $display("FAIL reset_jam got %b want 0", jam); end
    n_chk++; if (remaining !== 3'd0) begin n_fail++; $display("FAIL reset_remaining got %0d want 0", remaining); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero;
    bit busy_seen = 0, coin_seen = 0;
    @(negedge clk);
    req = 1'b1; change = 3'd0;
    @(negedge clk);
    req = 1'b0;
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
    for (int i = 0; i < 4; i++) begin
      busy_seen |= busy;
      coin_seen |= coin_out;
      @(negedge clk);
      if (i == 0) begin
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse got %b want 0", done); end
      end
    end
    n_chk++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b want 0", busy_seen); end
    n_chk++; if (coin_seen !== 1'b0) begin n_fail++; $display("FAIL zero_coin_out got %b want 0", coin_seen); end
  endtask

  // mid: loop cycle at which a stray req (change=7) is driven while busy; 0 = none
  task automatic test_payout(input int c, input int dly, input int mid);
    int exp_n, exp_rem, rises, first, lowrun, expv;
    bit prev, fin;
    exp_n = (c > COIN_MAX) ? COIN_MAX : c;
    exp_q.push_back(exp_n);
    hop_dly = dly; hop_en = 1'b1;
    exp_rem = exp_n; rises = 0; first = -1; lowrun = 0; prev = 0; fin = 0;
    @(negedge clk);
    req = 1'b1; change = 3'(c);
    for (int i = 1; i <= 400 && !fin; i++) begin
      @(negedge clk);
      if (i == mid) begin req = 1'b1; change = 3'd7; end
      else req = 1'b0;
      if (i == 1) begin
        n_chk++; if (coin_out !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL start_latency got coin_out=%b busy=%b want 1 1", coin_out, busy); end
      end
      if (coin_out && !prev) begin
        rises++;
        if (first < 0) first = i;
        if (rises > 1) begin
          n_chk++; if (lowrun !== GAP_W) begin n_fail++; $display("FAIL gap_len got %0d want %0d", lowrun, GAP_W); end
        end
        n_chk++; if (remaining !== 3'(exp_rem)) begin n_fail++; $display("FAIL rem_at_feed got %0d want %0d", remaining, exp_rem); end
      end
      if (!coin_out && prev) begin
        exp_rem--;
        n_chk++; if (remaining !== 3'(exp_rem)) begin n_fail++; $display("FAIL rem_dec got %0d want %0d", remaining, exp_rem); end
      end
      lowrun = coin_out ? 0 : lowrun + 1;
      if (done) begin
        fin = 1;
        expv = exp_q.pop_front();
        n_chk++; if (rises !== expv) begin n_fail++; $display("FAIL coin_count got %0d want %0d", rises, expv); end
        n_chk++; if (busy !== 1'b0 || coin_out !== 1'b0) begin n_fail++; $display("FAIL done_busy got busy=%b coin_out=%b want 0 0", busy, coin_out); end
        n_chk++; if (remaining !== 3'd0) begin n_fail++; $display("FAIL done_remaining got %0d want 0", remaining); end
        if (dly == 0) begin
          n_chk++; if ((i - first) !== expv * (1 + GAP_W)) begin n_fail++; $display("FAIL payout_latency got %0d want %0d", i - first, expv * (1 + GAP_W)); end
        end
      end
      prev = coin_out;
    end
    req = 1'b0;
    n_chk++; if (!fin) begin n_fail++; $display("FAIL payout_timeout got no done want done"); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0 || coin_out !== 1'b0) begin n_fail++; $display("FAIL done_single got done=%b coin_out=%b want 0 0", done, coin_out); end
    hop_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    int rises = 0;
    bit prev = 0, hit = 0;
    hop_dly = 0; hop_en = 1'b1;
    @(negedge clk);
    req = 1'b1; change = 3'd3;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (coin_out && !prev) rises++;
      prev = coin_out;
      if (rises == 2) begin
        hit = 1;
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (remaining !== 3'd0) begin n_fail++; $display("FAIL rstmid_remaining got %0d want 0", remaining); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_chk++; if (coin_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_coin_out got %b want 0", coin_out); end
        rst_n = 1'b1;
      end
    end
    n_chk++; if (!hit) begin n_fail++; $display("FAIL rstmid_timeout got %0d coins want 2", rises); end
    hop_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

`ifdef CHANGE_DISP_TIMEOUT_EN
  task automatic test_jam;
    int hi = 0;
    bit seen = 0;
    hop_en = 1'b0;
    @(negedge clk);
    req = 1'b1; change = 3'd2;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (coin_out) hi++;
      if (jam) seen = 1;
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL jam_timeout got jam=0 want 1"); end
    n_chk++; if (hi !== TIMEOUT) begin n_fail++; $display("FAIL jam_feed_len got %0d want %0d", hi, TIMEOUT); end
    n_chk++; if (coin_out !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL jam_outputs got coin_out=%b busy=%b want 0 1", coin_out, busy); end
    n_chk++; if (remaining !== 3'd2) begin n_fail++; $display("FAIL jam_remaining got %0d want 2", remaining); end
    repeat (3) @(negedge clk);
    n_chk++; if (jam !== 1'b1 || remaining !== 3'd2) begin n_fail++; $display("FAIL jam_hold got jam=%b rem=%0d want 1 2", jam, remaining); end
    clr = 1'b1; req = 1'b1; change = 3'd1;
    @(negedge clk);
    clr = 1'b0; req = 1'b0;
    n_chk++; if (jam !== 1'b0 || busy !== 1'b0 || remaining !== 3'd0) begin n_fail++; $display("FAIL jam_clr got jam=%b busy=%b rem=%0d want 0 0 0", jam, busy, remaining); end
    @(negedge clk);
    n_chk++; if (coin_out !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL jam_req_dropped got coin_out=%b busy=%b want 0 0", coin_out, busy); end
  endtask
`else
  task automatic test_no_timeout;
    int hi = 0, falls = 0, expv;
    bit jam_seen = 0, fin = 0, prev = 1;
    exp_q.push_back(2);
    hop_en = 1'b0;
    @(negedge clk);
    req = 1'b1; change = 3'd2;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (coin_out) hi++;
      jam_seen |= jam;
    end
    n_chk++; if (hi !== 120) begin n_fail++; $display("FAIL notimeout_feed got %0d want 120", hi); end
    n_chk++; if (jam_seen !== 1'b0) begin n_fail++; $display("FAIL notimeout_jam got %b want 0", jam_seen); end
    hop_dly = 0; hop_en = 1'b1;
    for (int i = 0; i < 50 && !fin; i++) begin
      @(negedge clk);
      if (!coin_out && prev) falls++;
      prev = coin_out;
      if (done) begin
        fin = 1;
        expv = exp_q.pop_front();
        n_chk++; if (falls !== expv) begin n_fail++; $display("FAIL notimeout_coins got %0d want %0d", falls, expv); end
        n_chk++; if (remaining !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL notimeout_done got rem=%0d busy=%b want 0 0", remaining, busy); end
      end
    end
    n_chk++; if (!fin) begin n_fail++; $display("FAIL notimeout_wait got no done want done"); end
    hop_en = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_payout(3, 1, 0);
    test_payout(3, 0, 0);
    test_payout(1, 0, 0);
    test_payout(6, 0, 4);
    test_payout(7, 2, 6);
    test_reset_mid();
`ifdef CHANGE_DISP_TIMEOUT_EN
    test_jam();
`else
    test_no_timeout();
`endif
    test_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
